// File: rtl/spec_feeder.sv
// spec_feeder: buffers a spec byte stream and hands it to tsp one has_spec strobe at a time.
// Optional build macro SPEC_FEEDER_NLXLATE_EN rewrites NL_IN bytes as NL_OUT when popped.
module spec_feeder #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 16,
  parameter int                GAP    = 1,
  parameter logic [DATA_W-1:0] NL_IN  = DATA_W'(10),
  parameter logic [DATA_W-1:0] NL_OUT = DATA_W'(13),
  localparam int               AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] spec_data,
  output logic              has_spec,
  input  logic              ready_to_read,
  output logic              done,
  output logic [15:0]       sent_count,
  output logic [AW:0]       level
);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  entry_t              mem_q [DEPTH];
  entry_t              head;
  logic [AW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic                last_seen_q, last_seen_d;
  logic                full, empty, push, pop;

  state_t              state_q;
  logic [3:0]          gap_cnt_q;
  logic                last_pop_q;
  logic [DATA_W-1:0]   spec_data_q;
  logic                has_spec_q;
  logic                done_q;
  logic [15:0]         sent_cnt_q;

  function automatic logic [DATA_W-1:0] xlate(input logic [DATA_W-1:0] b);
`ifdef SPEC_FEEDER_NLXLATE_EN
    return (b == NL_IN) ? NL_OUT : b;
`else
    return b;
`endif
  endfunction

`ifndef SPEC_FEEDER_NLXLATE_EN
  logic unused_nl;
  assign unused_nl = ^{NL_IN, NL_OUT};
`endif

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign in_ready = !full && !last_seen_q && !done_q;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && !empty && ready_to_read;
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign level    = wptr_q - rptr_q;

  always_comb begin
    wptr_d      = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d      = pop  ? rptr_q + PTR_ONE : rptr_q;
    last_seen_d = last_seen_q | (push & in_last);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= '{last: in_last, data: in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      last_seen_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Delivery FSM; has_spec is only ever set from IDLE, so it cannot stay high two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= 4'd0;
      last_pop_q  <= 1'b0;
      spec_data_q <= '0;
      has_spec_q  <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt_q  <= 16'd0;
    end else begin
      has_spec_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q     <= S_STROBE;
            spec_data_q <= xlate(head.data);
            last_pop_q  <= head.last;
            has_spec_q  <= 1'b1;
          end
        end
        S_STROBE: begin
          if (sent_cnt_q != 16'hFFFF) sent_cnt_q <= sent_cnt_q + 16'd1;
          if (last_pop_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (GAP > 0) begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            if (last_pop_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: state_q <= S_DONE;
      endcase
    end
  end

  assign spec_data  = spec_data_q;
  assign has_spec   = has_spec_q;
  assign done       = done_q;
  assign sent_count = sent_cnt_q;

endmodule

// File: tb/tb_spec_feeder.sv
// Randomized self-checking bench for spec_feeder (DEPTH=4, GAP=1) with a queue-based delivery model.
module tb_spec_feeder;
  localparam int GAP = 1;
  localparam int LW  = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0, ready_to_read = 1'b0;
  logic        in_ready, has_spec, done;
  logic [7:0]  spec_data;
  logic [15:0] sent_count;
  logic [LW-1:0] level;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  bit prev_hs = 1'b0, rnd_rtr = 1'b0;

  spec_feeder #(.DATA_W(8), .DEPTH(4), .GAP(GAP), .NL_IN(8'd10), .NL_OUT(8'd13)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .spec_data(spec_data), .has_spec(has_spec),
    .ready_to_read(ready_to_read), .done(done), .sent_count(sent_count), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every delivered byte and its cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (has_spec) begin
        n_chk++;
        if (prev_hs) begin
          n_fail++;
          $display("FAIL strobe_consecutive: has_spec high two cycles at cyc %0d, required single-cycle", cyc);
        end
        got_q.push_back(spec_data);
        got_t.push_back(cyc);
      end
      prev_hs = has_spec;
    end else begin
      prev_hs = 1'b0;
    end
  end

  always @(negedge clk) if (rnd_rtr) ready_to_read = ($urandom_range(0, 3) != 0);

  function automatic logic [7:0] model_x(input logic [7:0] b);
`ifdef SPEC_FEEDER_NLXLATE_EN
    return (b == 8'h0A) ? 8'h0D : b;
`else
    return b;
`endif
  endfunction

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    ready_to_read = 1'b0; rnd_rtr = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); got_q.delete(); got_t.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Presents a byte until accepted (bounded); called and returns on a falling edge.
  task automatic push(input logic [7:0] b, input logic lst, output bit ok);
    int w = 0;
    in_valid = 1'b1; in_data = b; in_last = lst;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    ok = in_ready;
    if (ok) exp_q.push_back(model_x(b));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int w = 0;
    while (!done && w < 400) begin @(negedge clk); w++; end
    t = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; ready_to_read = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({in_ready, spec_data, has_spec, done, sent_count, level} !== {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", {in_ready, spec_data, has_spec, done, sent_count, level},
               {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 3'd0});
    end
    rst = 1'b1; ready_to_read = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({has_spec, level} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: has_spec/level=%b, required 0000", {has_spec, level});
    end
  endtask

  task automatic test_newline();
    int c0, td, bad = 0; bit ok;
    apply_reset();
    ready_to_read = 1'b1;
    c0 = cyc;
    push(8'h41, 1'b0, ok); if (!ok) bad++;
    push(8'h0A, 1'b0, ok); if (!ok) bad++;
    push(8'h42, 1'b1, ok); if (!ok) bad++;
    wait_done(td);
    repeat (3) @(negedge clk);
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL nl_push: %0d refused, required 0", bad); end
    n_chk++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL nl_count: %0d strobes, required 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nl_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    if (got_t.size() >= 3) begin
      n_chk++;
      if (got_t[0] - c0 !== 2) begin n_fail++; $display("FAIL nl_latency: %0d cycles, required 2", got_t[0] - c0); end
      for (int i = 1; i < 3; i++) begin
        n_chk++;
        if (got_t[i] - got_t[i-1] !== GAP + 2) begin
          n_fail++; $display("FAIL nl_spacing%0d: %0d, required %0d", i, got_t[i] - got_t[i-1], GAP + 2);
        end
      end
      n_chk++;
      if (td !== got_t[2] + 1) begin n_fail++; $display("FAIL nl_done_time: cyc %0d, required %0d", td, got_t[2] + 1); end
    end
    n_chk++; if (sent_count !== 16'd3) begin n_fail++; $display("FAIL nl_sent: %0d, required 3", sent_count); end
    n_chk++; if ({done, in_ready} !== 2'b10) begin n_fail++; $display("FAIL nl_done_ready: %b, required 10", {done, in_ready}); end
  endtask

  task automatic test_full();
    int td, bad = 0; bit ok; logic [7:0] b;
    apply_reset();
    for (int i = 0; i < 4; i++) begin b = 8'($urandom); push(b, 1'b0, ok); if (!ok) bad++; end
    repeat (3) @(negedge clk);
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL full_push: %0d refused, required 0", bad); end
    n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: %0d, required 4", level); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: %b, required 0", in_ready); end
    n_chk++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL full_nostrobe: %0d strobes, required 0", got_q.size()); end
    b = 8'($urandom);
    in_valid = 1'b1; in_data = b; in_last = 1'b1; ready_to_read = 1'b1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle: in_ready=%b, required 0", in_ready); end
    @(negedge clk);
    n_chk++; if ({in_ready, level} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL full_slot_free: in_ready/level=%b/%0d, required 1/3", in_ready, level);
    end
    push(b, 1'b1, ok);
    wait_done(td);
    repeat (3) @(negedge clk);
    n_chk++; if (!ok || got_q.size() !== 5) begin n_fail++; $display("FAIL full_count: %0d strobes, required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (sent_count !== 16'd5) begin n_fail++; $display("FAIL full_sent: %0d, required 5", sent_count); end
  endtask

  task automatic test_rtr_toggle();
    int w = 0, m, td, bad = 0; bit ok;
    apply_reset();
    ready_to_read = 1'b1;
    push(8'($urandom), 1'b0, ok); if (!ok) bad++;
    while (!has_spec && w < 20) begin @(negedge clk); w++; end
    ready_to_read = 1'b0;
    n_chk++; if (has_spec !== 1'b1) begin n_fail++; $display("FAIL rtr_first: has_spec=%b, required 1", has_spec); end
    push(8'($urandom), 1'b0, ok); if (!ok) bad++;
    push(8'($urandom), 1'b1, ok); if (!ok) bad++;
    repeat (6) @(negedge clk);
    n_chk++; if (got_q.size() !== 1 || sent_count !== 16'd1) begin
      n_fail++; $display("FAIL rtr_hold: %0d strobes sent_count %0d, required 1/1", got_q.size(), sent_count);
    end
    n_chk++; if (level !== 3'd2) begin n_fail++; $display("FAIL rtr_level: %0d, required 2", level); end
    m = cyc;
    ready_to_read = 1'b1;
    wait_done(td);
    repeat (3) @(negedge clk);
    n_chk++; if (bad !== 0 || got_q.size() !== 3) begin
      n_fail++; $display("FAIL rtr_count: %0d strobes (%0d refused), required 3", got_q.size(), bad);
    end
    if (got_t.size() >= 2) begin
      n_chk++; if (got_t[1] - m !== 1) begin n_fail++; $display("FAIL rtr_resume: %0d cycles, required 1", got_t[1] - m); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rtr_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_last_then_more();
    int td, bad = 0; bit ok;
    apply_reset();
    push(8'($urandom), 1'b0, ok); if (!ok) bad++;
    push(8'($urandom), 1'b1, ok); if (!ok) bad++;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL last_refuse%0d: in_ready=%b, required 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (level !== 3'd2) begin n_fail++; $display("FAIL last_level: %0d, required 2", level); end
    ready_to_read = 1'b1;
    wait_done(td);
    repeat (4) @(negedge clk);
    n_chk++; if (bad !== 0 || got_q.size() !== 2) begin
      n_fail++; $display("FAIL last_count: %0d strobes (%0d refused), required 2", got_q.size(), bad);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL last_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    if (exp_q.size() == 2) begin
      n_chk++;
      if ({done, has_spec, spec_data} !== {1'b1, 1'b0, exp_q[1]}) begin
        n_fail++; $display("FAIL last_hold: done/has_spec/data=%b/%b/%h, required 1/0/%h", done, has_spec, spec_data, exp_q[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset();
    for (int i = 0; i < 3; i++) push(8'($urandom), 1'b0, ok);
    ready_to_read = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, spec_data, has_spec, done, sent_count, level} !== {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required %h", {in_ready, spec_data, has_spec, done, sent_count, level},
               {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 3'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int td, bad = 0; bit ok; logic [7:0] b;
    apply_reset();
    rnd_rtr = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      push(b, (i == n - 1), ok); if (!ok) bad++;
    end
    wait_done(td);
    rnd_rtr = 1'b0; ready_to_read = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_done: %b, required 1", done); end
    n_chk++; if (bad !== 0 || got_q.size() !== n) begin
      n_fail++; $display("FAIL rnd_count: %0d strobes (%0d refused), required %0d", got_q.size(), bad, n);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        n_chk++;
        if (got_t[i] - got_t[i-1] < GAP + 2) begin
          n_fail++; $display("FAIL rnd_spacing%0d: %0d, required >= %0d", i, got_t[i] - got_t[i-1], GAP + 2);
        end
      end
    end
    n_chk++; if (sent_count !== 16'(n)) begin n_fail++; $display("FAIL rnd_sent: %0d, required %0d", sent_count, n); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_newline();
    test_full();
    test_rtr_toggle();
    test_last_then_more();
    test_async_reset();
    test_random(12);
    test_random(24);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
